// File: rtl/sign_mag_decoder.sv
// Two's-complement to sign/magnitude converter; negative inputs are re-negated one bit per clock.
// Optional MINNEG_FLAG_EN adds out_minneg, flagging the most negative input value.
module sign_mag_decoder #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_mag,
  output logic         out_sign
`ifdef MINNEG_FLAG_EN
  ,output logic        out_minneg
`endif
);

  // state | meaning
  // IDLE  | waiting for an operand, in_ready high
  // BUSY  | serially negating a negative operand, one bit per clock
  // DONE  | result held on out_* until the consumer takes it
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t        state, state_nxt;
  logic [N-1:0]  x;
  logic [CW-1:0] cnt;
  logic          carry;
  logic          rdy_q;
  logic          accept;
  logic          handoff;

  // in_ready is its own flop so it reads 0 during reset and rises one edge later.
  assign in_ready  = rdy_q;
  assign out_valid = (state == DONE);
  assign accept    = in_valid & rdy_q;
  assign handoff   = (state == DONE) & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rdy_q <= 1'b0;
    end else begin
      state <= state_nxt;
      rdy_q <= (state_nxt == IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = in_data[N-1] ? BUSY : DONE;
      BUSY: if (cnt == CNT_LAST) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // x shifts right so bit cnt is always at x[0]; the magnitude fills in from the top.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      out_mag  <= '0;
      out_sign <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            x        <= in_data;
            out_sign <= in_data[N-1];
            carry    <= 1'b1;
            cnt      <= '0;
            if (!in_data[N-1]) out_mag <= in_data;
          end
        end
        BUSY: begin
          x       <= x >> 1;
          out_mag <= {~x[0] ^ carry, out_mag[N-1:1]};
          carry   <= ~x[0] & carry;
          cnt     <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MINNEG_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_minneg <= 1'b0;
    end else if (accept) begin
      out_minneg <= (in_data == {1'b1, {(N-1){1'b0}}});
    end else if (handoff) begin
      out_minneg <= 1'b0;
    end
  end
`endif

endmodule
